// File: rtl/ram_sp_arbiter_rr.sv
// Two-requester round-robin arbiter and sequencer in front of a single-port
// synchronous RAM with 1-cycle read latency; read data is routed back to its owner.
module ram_sp_arbiter_rr #(
   parameter int DATA_WITH = 8,
   parameter int ADDR_WITH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_WITH-1:0] a_addr,
   input  logic [DATA_WITH-1:0] a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [DATA_WITH-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_WITH-1:0] b_addr,
   input  logic [DATA_WITH-1:0] b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [DATA_WITH-1:0] b_rdata,
   output logic [ADDR_WITH-1:0] ram_addr,
   output logic [DATA_WITH-1:0] ram_q,
   output logic                 ram_we,
   output logic                 ram_oe,
   input  logic [DATA_WITH-1:0] ram_rd_q
);

   typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

   ptr_e                 last_gnt_q, last_gnt_d;

   logic                 vld_p0;
   logic                 we_p0;
   logic                 own_p0;
   logic [ADDR_WITH-1:0] addr_p0;
   logic [DATA_WITH-1:0] wdata_p0;

   logic [ADDR_WITH-1:0] addr_p1_q, addr_p1_d;
   logic [DATA_WITH-1:0] wdata_p1_q, wdata_p1_d;
   logic                 we_p1_q, we_p1_d;
   logic                 oe_p1_q, oe_p1_d;
   logic                 vld_p1_q, vld_p1_d;
   logic                 own_p1_q, own_p1_d;

   logic                 vld_p2_q, vld_p2_d;
   logic                 own_p2_q, own_p2_d;

   logic                 a_rvalid_q, a_rvalid_d;
   logic                 b_rvalid_q, b_rvalid_d;
   logic [DATA_WITH-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_WITH-1:0] b_rdata_q, b_rdata_d;

   // Stage 0: combinational arbitration; on contention the loser of the last grant wins
   always_comb begin
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      last_gnt_d = last_gnt_q;
      if (rst_n) begin
         if (a_req && b_req) begin
            if (last_gnt_q == PTR_A) b_gnt = 1'b1;
            else                     a_gnt = 1'b1;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
         if (a_gnt)      last_gnt_d = PTR_A;
         else if (b_gnt) last_gnt_d = PTR_B;
      end
   end

   assign vld_p0   = a_gnt | b_gnt;
   assign own_p0   = b_gnt;
   assign we_p0    = b_gnt ? b_we    : a_we;
   assign addr_p0  = b_gnt ? b_addr  : a_addr;
   assign wdata_p0 = b_gnt ? b_wdata : a_wdata;

   // Stage 1: granted command onto the RAM port; idle cycles keep addr/q but drop we/oe
   always_comb begin
      addr_p1_d  = addr_p1_q;
      wdata_p1_d = wdata_p1_q;
      we_p1_d    = 1'b0;
      oe_p1_d    = 1'b0;
      vld_p1_d   = 1'b0;
      own_p1_d   = own_p1_q;
      if (vld_p0) begin
         addr_p1_d  = addr_p0;
         wdata_p1_d = wdata_p0;
         we_p1_d    = we_p0;
         oe_p1_d    = ~we_p0;
         vld_p1_d   = ~we_p0;
         own_p1_d   = own_p0;
      end
   end

   // Stage 2: read tag waits while the RAM registers its output
   assign vld_p2_d = vld_p1_q;
   assign own_p2_d = own_p1_q;

   // Stage 3: ram_rd_q is only muxed in when a read tag arrives, so a floating bus is never captured
   always_comb begin
      a_rvalid_d = vld_p2_q & ~own_p2_q;
      b_rvalid_d = vld_p2_q &  own_p2_q;
      a_rdata_d  = a_rvalid_d ? ram_rd_q : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? ram_rd_q : b_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt_q <= PTR_A;
         addr_p1_q  <= '0;
         wdata_p1_q <= '0;
         we_p1_q    <= 1'b0;
         oe_p1_q    <= 1'b0;
         vld_p1_q   <= 1'b0;
         own_p1_q   <= 1'b0;
         vld_p2_q   <= 1'b0;
         own_p2_q   <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         addr_p1_q  <= addr_p1_d;
         wdata_p1_q <= wdata_p1_d;
         we_p1_q    <= we_p1_d;
         oe_p1_q    <= oe_p1_d;
         vld_p1_q   <= vld_p1_d;
         own_p1_q   <= own_p1_d;
         vld_p2_q   <= vld_p2_d;
         own_p2_q   <= own_p2_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign ram_addr = addr_p1_q;
   assign ram_q    = wdata_p1_q;
   assign ram_we   = we_p1_q;
   assign ram_oe   = oe_p1_q;
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule
